// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional in-flight cancel is enabled by defining MD_CANCEL_EN.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
`ifdef MD_CANCEL_EN
    input  logic        cancel_i,
`endif
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OpNone  = 3'd0;
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            cancel;

`ifdef MD_CANCEL_EN
    assign cancel = cancel_i;
`else
    assign cancel = 1'b0;
`endif

    // Restoring shift-subtract division; returns {remainder, quotient}.
    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        logic [32:0] rem;
        logic [31:0] q;
        rem = '0;
        q   = n;
        for (int i = 0; i < 32; i++) begin
            rem = {rem[31:0], q[31]};
            q   = {q[30:0], 1'b0};
            if (rem >= {1'b0, d}) begin
                rem  = rem - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        return {rem[31:0], q};
    endfunction

    // Datapath on the captured operands
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] div_raw;
    logic [31:0] quot, rem;

    always_comb begin
        mul_signed = (op_q == OpMult);
        // Sign-extending to 64 bits makes the low 64 bits of the product correct for both cases.
        mul_a   = {{32{a_q[31] & mul_signed}}, a_q};
        mul_b   = {{32{b_q[31] & mul_signed}}, b_q};
        product = mul_a * mul_b;

        div_signed = (op_q == OpDiv);
        a_neg      = div_signed & a_q[31];
        b_neg      = div_signed & b_q[31];
        a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
        div_raw    = udiv(a_mag, b_mag);
        // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
        quot       = (a_neg ^ b_neg) ? (~div_raw[31:0] + 32'd1) : div_raw[31:0];
        rem        = a_neg ? (~div_raw[63:32] + 32'd1) : div_raw[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            StIdle: begin
                if (start_i && !cancel) begin
                    case (op_i)
                        OpMult, OpMultu: begin
                            op_d    = op_i;
                            a_d     = a_i;
                            b_d     = b_i;
                            cnt_d   = CntW'(MULT_CYCLES);
                            state_d = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            op_d    = op_i;
                            a_d     = a_i;
                            b_d     = b_i;
                            cnt_d   = CntW'(DIV_CYCLES);
                            state_d = StBusy;
                        end
                        OpMthi:  hi_d = a_i;
                        OpMtlo:  lo_d = a_i;
                        OpNone:  ;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (op_q == OpMult || op_q == OpMultu) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == StBusy);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpNone;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; covers cancel when MD_CANCEL_EN is defined.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
`ifdef MD_CANCEL_EN
        .cancel_i(cancel),
`endif
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then return inputs to idle.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Count samples with busy high; bounded so a stuck busy cannot hang the run.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mtx();
        issue(3'd5, 32'h0000_1234, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b want 0", busy); end
        tests++; if (hi !== 32'h0000_1234) begin fails++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
        issue(3'd6, 32'h0000_5678, 32'h0);
        tests++; if (lo !== 32'h0000_5678) begin fails++; $display("FAIL mtlo_lo: got %h want 00005678", lo); end
        tests++; if (hi !== 32'h0000_1234) begin fails++; $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); end
    endtask

    task automatic test_mult();
        int n;
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_busy(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL mult_cycles: got %0d want 5", n); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_busy(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL multu_cycles: got %0d want 5", n); end
        tests++; if (hi !== 32'h0000_0001) begin fails++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        tests++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_busy(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL div_cycles: got %0d want 10", n); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n);
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        // Operands change during BUSY; the captured 100/7 must be used.
        issue(3'd4, 32'd100, 32'd7);
        a = 32'd9;
        b = 32'd3;
        wait_busy(n);
        tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_div_by_zero();
        int n;
        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        issue(3'd4, 32'd7, 32'd0);
        wait_busy(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL divz_cycles: got %0d want 10", n); end
        tests++; if (hi !== 32'h11) begin fails++; $display("FAIL divz_hi: got %h want 00000011", hi); end
        tests++; if (lo !== 32'h22) begin fails++; $display("FAIL divz_lo: got %h want 00000022", lo); end
    endtask

    task automatic test_start_while_busy();
        int n;
        issue(3'd1, 32'd3, 32'hFFFF_FFFE);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            start = (n == 2);
            op    = (n == 2) ? 3'd5 : 3'd0;
            a     = 32'h55;
            tick();
        end
        start = 1'b0;
        op    = 3'd0;
        tests++; if (n !== 5) begin fails++; $display("FAIL busy_start_cycles: got %0d want 5", n); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL busy_start_hi: got %h want ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL busy_start_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_none_reserved();
        issue(3'd0, 32'hDEAD_BEEF, 32'h1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL none_busy: got %b want 0", busy); end
        issue(3'd7, 32'hDEAD_BEEF, 32'h1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rsvd_busy: got %b want 0", busy); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rsvd_hi: got %h want ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL rsvd_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_reset_mid_op();
        int n;
        issue(3'd3, 32'd100, 32'd3);
        n = 0;
        while (busy === 1'b1 && n < 3) begin
            n++;
            tick();
        end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        tick();
        rst_n = 1'b1;
        tick();
        issue(3'd2, 32'd6, 32'd7);
        wait_busy(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL rstmid_multu_cycles: got %0d want 5", n); end
        tests++; if (lo !== 32'd42) begin fails++; $display("FAIL rstmid_multu_lo: got %h want 0000002a", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_multu_hi: got %h want 0", hi); end
    endtask

`ifdef MD_CANCEL_EN
    task automatic test_cancel();
        int n;
        issue(3'd5, 32'hAA, 32'h0);
        issue(3'd6, 32'hBB, 32'h0);
        issue(3'd3, 32'd100, 32'd3);
        n = 0;
        while (busy === 1'b1 && n < 4) begin
            n++;
            tick();
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cancel_busy: got %b want 0", busy); end
        tests++; if (hi !== 32'hAA) begin fails++; $display("FAIL cancel_hi: got %h want 000000aa", hi); end
        tests++; if (lo !== 32'hBB) begin fails++; $display("FAIL cancel_lo: got %h want 000000bb", lo); end
        cancel = 1'b1;
        issue(3'd5, 32'hCC, 32'h0);
        issue(3'd1, 32'd2, 32'd2);
        cancel = 1'b0;
        tests++; if (hi !== 32'hAA) begin fails++; $display("FAIL cancel_idle_hi: got %h want 000000aa", hi); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cancel_idle_busy: got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_mtx();
        test_mult();
        test_div();
        test_div_by_zero();
        test_start_while_busy();
        test_none_reserved();
        test_reset_mid_op();
`ifdef MD_CANCEL_EN
        test_cancel();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the register-file operands and decoded md opcode that the ID/EX register latches.
- Owns the architectural HI/LO registers and exposes busy to the hazard unit.
- The hazard unit freezes the front end while an md instruction in ID would collide with an in-flight operation.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a valid md instruction this cycle; held 0 by the bench/control when the stage is flushed.
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  HI register, driven directly from the flop.
- lo  output  32  LO register, driven directly from the flop.

Behaviour:
- Reset (reset_n low, async):
  - hi=0, lo=0, busy=0, state IDLE, counter=0.
  - Reset mid-operation discards the operation; HI/LO are cleared.
- States: IDLE, BUSY.
- IDLE with start=1, op in 1..4:
  - Latch a, b, op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1: write the result to HI/LO, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles; the new hi/lo are visible the same cycle busy falls.
- Results:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
  - Divide by zero: full DIV_CYCLES latency; HI/LO left unchanged.
- MTHI/MTLO in IDLE with start=1:
  - hi<=a or lo<=a at that edge.
  - busy stays 0; single cycle.
- Start while BUSY (any op): ignored.
  - The hazard unit guarantees it never occurs; the bench checks that no state changes.
- start=1 with op NONE or reserved: no effect.
- Operands are captured at start, so later changes on a/b during BUSY have no effect.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 in BUSY: return to IDLE at the next edge, busy=0, HI/LO unchanged. This supports exception/flush of an in-flight md instruction.
  - cancel=1 in IDLE: suppresses a same-cycle start, including MTHI/MTLO.
  - cancel has priority over completion on the same edge.
- Not defined: port absent; operations always run to completion.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 with hi/lo preset by MTHI 0x11, MTLO 0x22 -> busy high 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT started, then MTHI a=0x55 with start=1 at cycle 2 of BUSY -> MTHI ignored; product written at the end; busy timing unaffected.
- DIV in progress, reset_n low at cycle 4 -> busy=0, hi=lo=0 immediately; a new MULTU after release completes normally.
  - With MD_CANCEL_EN: cancel at cycle 4 instead -> busy=0 next edge, HI/LO hold their old values.
